// File: rtl/receive_buff_ctrl.sv
// receive_buff_ctrl: arbitrates the receive buffer port between NoC ingress writes and core tag reads.
module receive_buff_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_RETRY  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  net_valid,
    input  logic [TAG_WIDTH-1:0]  net_tag,
    input  logic [DATA_WIDTH-1:0] net_data,
    output logic                  net_ready,
    input  logic                  core_req,
    input  logic [TAG_WIDTH-1:0]  core_tag,
    output logic                  core_ack,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic                  core_err,
    output logic                  rb_ren,
    output logic                  rb_wen,
    output logic [TAG_WIDTH-1:0]  rb_tag,
    output logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  rb_empty,
    input  logic                  rb_full,
    input  logic                  rb_hit,
    input  logic [DATA_WIDTH-1:0] rb_data_out,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
    state_t                  state;
    logic                    last_wr;
    logic [3:0]              retry_cnt;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    wr_el, rd_el, grant_wr, grant_rd, last_try;
    // a tie goes to whichever side was not granted last
    always_comb begin
        wr_el    = net_valid && !rb_full;
        rd_el    = core_req && !rb_empty;
        grant_wr = state == IDLE && wr_el && (!rd_el || !last_wr);
        grant_rd = state == IDLE && rd_el && !grant_wr;
        last_try = retry_cnt + 4'd1 == 4'(MAX_RETRY);
    end
    assign net_ready = rst_n && grant_wr;
    assign rb_tag    = tag_q;
    assign rb_data   = data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            retry_cnt <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            rb_wen    <= 1'b0;
            rb_ren    <= 1'b0;
            core_ack  <= 1'b0;
            core_err  <= 1'b0;
            core_data <= '0;
            busy      <= 1'b0;
        end else begin
            rb_wen   <= 1'b0;
            rb_ren   <= 1'b0;
            core_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        tag_q   <= net_tag;
                        data_q  <= net_data;
                        rb_wen  <= 1'b1;
                        last_wr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= WR;
                    end else if (grant_rd) begin
                        tag_q   <= core_tag;
                        rb_ren  <= 1'b1;
                        last_wr <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RD;
                    end
                end
                WR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                RD: begin
                    if (rb_hit) begin
                        core_data <= rb_data_out;
                        core_err  <= 1'b0;
                        core_ack  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        retry_cnt <= retry_cnt + 4'd1;
                        core_data <= last_try ? '0 : core_data;
                        core_err  <= last_try;
                        core_ack  <= last_try;
                        busy      <= last_try;
                        state     <= last_try ? RESP : IDLE;
                    end
                end
                RESP: begin
                    retry_cnt <= '0;
                    core_err  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_receive_buff_ctrl.sv
// tb_receive_buff_ctrl: directed checks of arbitration, write/read timing, retries and async reset.
module tb_receive_buff_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       net_valid = 1'b0, net_ready, core_req = 1'b0, core_ack, core_err;
    logic [7:0] net_tag = '0, net_data = '0, core_tag = '0, core_data;
    logic       rb_ren, rb_wen, rb_empty = 1'b0, rb_full = 1'b0, rb_hit, busy;
    logic [7:0] rb_tag, rb_data, rb_data_out;
    logic [255:0] vld = '0;
    logic [7:0]   mem [256];
    int passed = 0, fails = 0, total = 0;

    receive_buff_ctrl dut (
        .clk(clk), .rst_n(rst_n), .net_valid(net_valid), .net_tag(net_tag), .net_data(net_data),
        .net_ready(net_ready), .core_req(core_req), .core_tag(core_tag), .core_ack(core_ack),
        .core_data(core_data), .core_err(core_err), .rb_ren(rb_ren), .rb_wen(rb_wen),
        .rb_tag(rb_tag), .rb_data(rb_data), .rb_empty(rb_empty), .rb_full(rb_full),
        .rb_hit(rb_hit), .rb_data_out(rb_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // tag-addressed buffer model
    always @(posedge clk) if (rb_wen) begin
        mem[rb_tag] <= rb_data;
        vld[rb_tag] <= 1'b1;
    end
    assign rb_hit      = vld[rb_tag];
    assign rb_data_out = vld[rb_tag] ? mem[rb_tag] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq [4];
        int n, cw, cr, nr, rn, bz, wn;
        logic got;
        net_valid = 1'b1; net_tag = 8'h12; net_data = 8'hA5;
        core_req = 1'b1; core_tag = 8'h12;
        repeat (3) step();
        chk("rst_ctrl", {net_ready, rb_wen, rb_ren, core_ack, core_err, busy}, 0);
        chk("rst_bus", {core_data, rb_tag, rb_data}, 0);
        rst_n = 1'b1;
        #1 chk("first_tie_write", net_ready, 1);
        step();
        chk("wr_wen", {rb_wen, rb_ren, busy, net_ready}, 4'b1010);
        chk("wr_tag_data", {rb_tag, rb_data}, 16'h12A5);
        net_valid = 1'b0;
        step();
        chk("wr_idle", {rb_wen, busy, net_ready}, 0);
        step();
        chk("rd_ren", {rb_ren, rb_wen, busy}, 3'b101);
        chk("rd_tag", rb_tag, 8'h12);
        step();
        chk("rd_ack", {core_ack, core_err, core_data}, 10'h2A5);
        core_req = 1'b0;
        step();
        chk("rd_done", {core_ack, busy}, 0);

        net_valid = 1'b1; net_tag = 8'h30; net_data = 8'h3C;
        core_req = 1'b1; core_tag = 8'h12;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            step();
            if (rb_wen) begin seq[n] = "W"; n++; end
            if (rb_ren) begin seq[n] = "R"; n++; end
            if (core_ack) core_tag ^= 8'h22;
        end
        chk("alt_count", n, 4);
        chk("alt0", seq[0], "W");
        chk("alt1", seq[1], "R");
        chk("alt2", seq[2], "W");
        chk("alt3", seq[3], "R");

        rb_full = 1'b1;
        cw = 0; cr = 0; nr = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cw += int'(rb_wen); cr += int'(rb_ren); nr += int'(net_ready);
            if (core_ack) core_tag ^= 8'h22;
        end
        chk("full_no_wr", cw, 0);
        chk("full_no_ready", nr, 0);
        chk("full_reads", cr, 4);
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin step(); got = core_ack; end
        chk("full_last_ack", got, 1);
        core_req = 1'b0; net_valid = 1'b0; rb_full = 1'b0;
        step();

        rb_empty = 1'b1; core_req = 1'b1; core_tag = 8'h55;
        rn = 0; bz = 0;
        for (int i = 0; i < 8; i++) begin step(); rn += int'(rb_ren); bz += int'(busy); end
        chk("empty_wait", {rn[7:0], bz[7:0]}, 0);
        rb_empty = 1'b0;
        rn = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (rb_ren) begin
                rn++;
                if (rn == 1) chk("miss_tag", rb_tag, 8'h55);
            end
            got = core_ack;
        end
        chk("miss_ack", got, 1);
        chk("miss_attempts", rn, 4);
        chk("miss_err", {core_err, core_data}, 9'h100);
        core_req = 1'b0;
        step();
        chk("miss_err_clear", {core_err, core_ack, busy}, 0);

        core_req = 1'b1;
        rn = 0; wn = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (rb_wen) begin net_valid = 1'b0; wn++; end
            if (rb_ren) begin
                rn++;
                if (rn == 2) begin net_valid = 1'b1; net_tag = 8'h55; net_data = 8'h77; end
            end
            got = core_ack;
        end
        chk("inj_ack", got, 1);
        chk("inj_attempts", rn, 3);
        chk("inj_writes", wn, 1);
        chk("inj_hit", {core_err, core_data}, 9'h077);
        core_req = 1'b0;
        step();

        net_valid = 1'b1; net_tag = 8'h66; net_data = 8'h99;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin step(); got = rb_wen; end
        chk("rst_wr_reached", got, 1);
        rst_n = 1'b0;
        #1 chk("rst_async", {rb_wen, busy, net_ready}, 0);
        chk("rst_async_bus", {rb_tag, rb_data}, 0);
        step();
        step();
        chk("rst_hold_ready", net_ready, 0);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", net_ready, 1);
        step();
        chk("post_rst_wr", {rb_wen, rb_tag, rb_data}, 17'h16699);
        net_valid = 1'b0; core_req = 1'b1; core_tag = 8'h66;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin step(); got = core_ack; end
        chk("post_rst_rd_ack", got, 1);
        chk("post_rst_rd", {core_err, core_data}, 9'h099);
        core_req = 1'b0;
        step();
        chk("final_idle", {busy, core_ack, rb_ren, rb_wen}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
